// File: rtl/wb_trace_monitor.sv
// Register-writeback trace monitor: captures (rd, data, pc) of every architectural
// write into a circular buffer and flags program halt when the fetch PC stops moving.
module wb_trace_monitor #(
    parameter int XLEN        = 32,
    parameter int RA_W        = 5,
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 8,
    parameter int WRAP_MODE   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    input  logic [RA_W-1:0]            wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic [XLEN-1:0]            wb_pc,
    input  logic [XLEN-1:0]            pc,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [RA_W-1:0]            rd_rd,
    output logic [XLEN-1:0]            rd_data,
    output logic [XLEN-1:0]            rd_pc,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       halted,
    output logic [XLEN-1:0]            halt_pc
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);
    localparam int SC_W = $clog2(STALL_LIMIT+1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state;
    logic [RA_W-1:0] mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [SC_W-1:0] stall_cnt;
    logic [XLEN-1:0] prev_pc;
    logic            prev_vld;

    logic push, pop, full, wr_en, drop_head, same;

    always_comb begin
        push      = wb_valid && (wb_rd != '0) && (state == RUN);
        pop       = rd_en && (count != '0);
        full      = (count == CW'(DEPTH));
        // In wrap mode a full push without a pop evicts the oldest entry.
        wr_en     = push && (pop || !full || (WRAP_MODE != 0));
        drop_head = push && full && !pop && (WRAP_MODE != 0);
        // prev_vld makes the first cycle after reset always count as a PC change.
        same      = prev_vld && (pc == prev_pc);
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_rd[tail]   <= wb_rd;
            mem_data[tail] <= wb_data;
            mem_pc[tail]   <= wb_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            halted    <= 1'b0;
            halt_pc   <= '0;
            rd_valid  <= 1'b0;
            rd_rd     <= '0;
            rd_data   <= '0;
            rd_pc     <= '0;
            stall_cnt <= '0;
            prev_pc   <= '0;
            prev_vld  <= 1'b0;
            state     <= RUN;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_rd   <= mem_rd[head];
                rd_data <= mem_data[head];
                rd_pc   <= mem_pc[head];
            end
            if (wr_en)
                tail <= tail + AW'(1);
            if (pop || drop_head)
                head <= head + AW'(1);
            if (push && !pop && !full)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (push && full && !pop)
                overflow <= 1'b1;

            prev_pc  <= pc;
            prev_vld <= 1'b1;
            if (!same)
                stall_cnt <= '0;
            else if (stall_cnt != {SC_W{1'b1}})
                stall_cnt <= stall_cnt + SC_W'(1);

            case (state)
                RUN: begin
                    if (same && stall_cnt == SC_W'(STALL_LIMIT-2)) begin
                        state   <= HALTED;
                        halted  <= 1'b1;
                        halt_pc <= pc;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_trace_monitor.sv
// Bench: drop-mode and wrap-mode monitors share stimulus; each is compared every
// cycle against a list-based model of the trace buffer and a PC run-length model.
module tb_wb_trace_monitor;
    localparam int XLEN = 32, RA_W = 5, DEPTH = 4, SL = 8;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] d;
        logic [XLEN-1:0] p;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, wb_valid, rd_en;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data, wb_pc, pc;

    logic            rv   [2];
    logic [RA_W-1:0] rrd  [2];
    logic [XLEN-1:0] rdat [2];
    logic [XLEN-1:0] rpc  [2];
    logic [2:0]      cnt  [2];
    logic            ovf  [2];
    logic            hlt  [2];
    logic [XLEN-1:0] hpc  [2];

    wb_trace_monitor #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .STALL_LIMIT(SL), .WRAP_MODE(0)) u_drop (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .pc(pc), .rd_en(rd_en), .rd_valid(rv[0]), .rd_rd(rrd[0]),
        .rd_data(rdat[0]), .rd_pc(rpc[0]), .count(cnt[0]), .overflow(ovf[0]),
        .halted(hlt[0]), .halt_pc(hpc[0]));

    wb_trace_monitor #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .STALL_LIMIT(SL), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_pc(wb_pc), .pc(pc), .rd_en(rd_en), .rd_valid(rv[1]), .rd_rd(rrd[1]),
        .rd_data(rdat[1]), .rd_pc(rpc[1]), .count(cnt[1]), .overflow(ovf[1]),
        .halted(hlt[1]), .halt_pc(hpc[1]));

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: index 0 = drop mode, 1 = wrap mode; entries kept oldest-first in a list.
    ent_t            mb [2][DEPTH];
    int              mc [2];
    logic            m_ovf [2];
    logic            m_rv [2];
    ent_t            m_last [2];
    logic            m_halt;
    logic [XLEN-1:0] m_hpc, prv;
    int              run;
    logic            first;
    logic            pc_hold;

    task automatic shift_out(input int m);
        for (int i = 0; i < DEPTH-1; i++) mb[m][i] = mb[m][i+1];
        mc[m]--;
    endtask

    task automatic model_step();
        ent_t e;
        logic push, pop;
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                mc[m] = 0; m_ovf[m] = 0; m_rv[m] = 0; m_last[m] = '0;
            end
            m_halt = 0; m_hpc = '0; run = 0; first = 1;
        end else begin
            e    = '{rd: wb_rd, d: wb_data, p: wb_pc};
            push = wb_valid && (wb_rd != 0) && !m_halt;
            for (int m = 0; m < 2; m++) begin
                pop     = rd_en && (mc[m] != 0);
                m_rv[m] = pop;
                if (pop) begin
                    m_last[m] = mb[m][0];
                    shift_out(m);
                end
                if (push) begin
                    if (mc[m] < DEPTH) begin
                        mb[m][mc[m]] = e;
                        mc[m]++;
                    end else begin
                        m_ovf[m] = 1;
                        if (m == 1) begin
                            shift_out(m);
                            mb[m][mc[m]] = e;
                            mc[m]++;
                        end
                    end
                end
            end
            if (first || pc != prv) run = 1;
            else run++;
            prv   = pc;
            first = 0;
            if (!m_halt && run >= SL) begin
                m_halt = 1;
                m_hpc  = pc;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rd_valid[%0d]", m), 64'(rv[m]),   64'(m_rv[m]));
            chk($sformatf("rd_rd[%0d]", m),    64'(rrd[m]),  64'(m_last[m].rd));
            chk($sformatf("rd_data[%0d]", m),  64'(rdat[m]), 64'(m_last[m].d));
            chk($sformatf("rd_pc[%0d]", m),    64'(rpc[m]),  64'(m_last[m].p));
            chk($sformatf("count[%0d]", m),    64'(cnt[m]),  64'(mc[m]));
            chk($sformatf("overflow[%0d]", m), 64'(ovf[m]),  64'(m_ovf[m]));
            chk($sformatf("halted[%0d]", m),   64'(hlt[m]),  64'(m_halt));
            chk($sformatf("halt_pc[%0d]", m),  64'(hpc[m]),  64'(m_hpc));
        end
        if (!pc_hold) pc = pc + 32'd4;
    endtask

    task automatic do_reset();
        reset = 1; cyc(); reset = 0;
    endtask

    task automatic push(input int rd, input logic [XLEN-1:0] d, input logic [XLEN-1:0] p);
        wb_valid = 1; wb_rd = RA_W'(rd); wb_data = d; wb_pc = p; rd_en = 0;
        cyc();
        wb_valid = 0;
    endtask

    task automatic pop(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1; cyc(); rd_en = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int hold_left;
        reset = 1; wb_valid = 0; wb_rd = '0; wb_data = '0; wb_pc = '0; rd_en = 0;
        pc = 32'h100; pc_hold = 0;
        cyc(); cyc();
        reset = 0;

        // Basic FIFO order
        for (int i = 1; i <= 3; i++) push(i, 32'hA0 + i, 32'(4*(i-1)));
        pop(3); idle(2);
        // x0 writes and empty pops
        push(0, 32'hDEAD, 32'h0);
        pop(1); idle(1);
        // Overfill: wrap keeps newest, drop keeps oldest
        for (int i = 1; i <= 6; i++) push(i, 32'hB0 + i, 32'(4*i));
        pop(5); idle(1);
        // Full with simultaneous push/pop, then empty with push/pop
        do_reset();
        for (int i = 1; i <= 4; i++) push(i, 32'hC0 + i, 32'(4*i));
        wb_valid = 1; wb_rd = 5'd9; wb_data = 32'hC9; wb_pc = 32'h90; rd_en = 1;
        cyc();
        wb_valid = 0; rd_en = 0;
        pop(5);
        wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hC7; wb_pc = 32'h70; rd_en = 1;
        cyc();
        wb_valid = 0; rd_en = 0;
        pop(1);
        // Halt on stuck PC; pushes ignored afterwards
        do_reset();
        pc_hold = 1; pc = 32'h40;
        idle(SL + 2);
        push(5, 32'hE5, 32'h40);
        idle(1);
        // PC moving every 7 cycles never halts
        do_reset();
        for (int k = 0; k < 6; k++) begin
            pc = 32'h200 + 32'(4*k);
            idle(7);
        end
        // Reset while holding entries and halted
        pc_hold = 0;
        do_reset();
        for (int i = 1; i <= 3; i++) push(i, 32'hD0 + i, 32'(4*i));
        pc_hold = 1; pc = 32'h80;
        idle(SL + 2);
        do_reset();
        pc = 32'h300;
        idle(2);

        // Random traffic with occasional PC stalls and resets
        hold_left = 0;
        for (int n = 0; n < 2000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            wb_valid = $urandom_range(0, 1);
            wb_rd    = RA_W'($urandom_range(0, 7));
            wb_data  = $urandom;
            wb_pc    = $urandom;
            rd_en    = ($urandom_range(0, 2) == 0);
            if (hold_left > 0) hold_left--;
            else begin
                pc = pc + 32'd4;
                if ($urandom_range(0, 15) == 0) hold_left = $urandom_range(1, 12);
            end
            cyc();
        end
        reset = 0; wb_valid = 0; rd_en = 0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
